// File: rtl/snoop_pkg.sv
`default_nettype none
// ============================================================================
// snoop_pkg : shared types and helpers for the packet snooper byte-count path
// Rev 1.0
// ============================================================================
package snoop_pkg;

   localparam int KEEP_MAX = 128;
   localparam int POP_W    = 8;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_SYNC = 2'd1,
      ST_IDLE = 2'd2,
      ST_BUSY = 2'd3
   } state_e;

   function automatic logic [POP_W-1:0] popcount(input logic [KEEP_MAX-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < KEEP_MAX; i++) begin
         n = n + POP_W'(v[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_rec_fifo.sv
`default_nettype none
// ============================================================================
// snoop_rec_fifo : DEPTH-entry record FIFO, push accepted when full if popping
// Rev 1.0
// ============================================================================
module snoop_rec_fifo
   import snoop_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type REC_T = logic [32:0]
) (
   input  logic clk,
   input  logic areset,
   input  logic push_i,
   input  REC_T push_data_i,
   input  logic pop_i,
   output REC_T head_o,
   output logic empty_o,
   output logic full_o
);

   localparam int AW = $clog2(DEPTH);

   REC_T          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          pop_w;
   logic          push_w;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign pop_w   = pop_i && !empty_o;
   assign push_w  = push_i && (!full_o || pop_w);
   assign head_o  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_w) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push_w && !pop_w) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (!push_w && pop_w) begin
            count_q <= count_q - (AW+1)'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/snoop_pkt_sequencer.sv
`default_nettype none
// ============================================================================
// snoop_pkt_sequencer : passive per-packet byte/flit counter with record FIFO
// Rev 1.0
// ============================================================================
module snoop_pkt_sequencer
   import snoop_pkg::*;
#(
   parameter int TDATA_WIDTH = 64,
   parameter int TKEEP_WIDTH = TDATA_WIDTH/8,
   parameter int CNT_WIDTH   = 16,
   parameter int REC_DEPTH   = 2
) (
   input  logic                   clk,
   input  logic                   areset,
   input  logic                   enable,
   input  logic                   mon_tvalid,
   input  logic                   mon_tready,
   input  logic                   mon_tlast,
   input  logic [TKEEP_WIDTH-1:0] mon_tkeep,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [CNT_WIDTH-1:0]   rec_bytes,
   output logic [CNT_WIDTH-1:0]   rec_flits,
   output logic                   rec_ovf,
   output logic [CNT_WIDTH-1:0]   drop_count,
   output logic                   busy
);

   typedef struct packed {
      logic [CNT_WIDTH-1:0] bytes;
      logic [CNT_WIDTH-1:0] flits;
      logic                 ovf;
   } rec_t;

   localparam int                   SW      = CNT_WIDTH + POP_W + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_e               state_q, state_d;
   logic                 beat_q, last_q;
   logic [POP_W-1:0]     nbytes_q;
   logic [CNT_WIDTH-1:0] bytes_q, bytes_d;
   logic [CNT_WIDTH-1:0] flits_q, flits_d;
   logic [CNT_WIDTH-1:0] drop_q;
   logic                 ovf_q, ovf_d;
   logic                 push_q, push_d;
   logic                 busy_q;
   logic                 take_w, start_w, bsat_w, fsat_w;
   logic                 pop_w, full_w, empty_w;
   logic [SW-1:0]        bsum_w, fsum_w;
   rec_t                 head_w, push_rec_w;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         beat_q   <= 1'b0;
         last_q   <= 1'b0;
         nbytes_q <= '0;
      end else begin
         beat_q   <= mon_tvalid && mon_tready;
         last_q   <= mon_tlast;
         nbytes_q <= popcount(KEEP_MAX'(mon_tkeep));
      end
   end

   // In IDLE a beat starts a fresh packet, so the accumulator base is zero.
   assign start_w = (state_q == ST_IDLE);
   assign bsum_w  = (start_w ? '0 : SW'(bytes_q)) + SW'(nbytes_q);
   assign fsum_w  = (start_w ? '0 : SW'(flits_q)) + SW'(1);
   assign bsat_w  = (bsum_w > SW'(CNT_MAX));
   assign fsat_w  = (fsum_w > SW'(CNT_MAX));

   always_comb begin
      state_d = state_q;
      bytes_d = bytes_q;
      flits_d = flits_q;
      ovf_d   = ovf_q;
      push_d  = 1'b0;
      take_w  = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (enable) begin
               state_d = (beat_q && !last_q) ? ST_SYNC : ST_IDLE;
            end
         end
         ST_SYNC: begin
            if (beat_q && last_q) begin
               state_d = enable ? ST_IDLE : ST_OFF;
            end
         end
         ST_IDLE: begin
            if (!enable) begin
               state_d = ST_OFF;
            end else if (beat_q) begin
               take_w  = 1'b1;
               state_d = last_q ? ST_IDLE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (beat_q) begin
               take_w = 1'b1;
               if (last_q) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_OFF;
      endcase
      if (take_w) begin
         bytes_d = bsat_w ? CNT_MAX : bsum_w[CNT_WIDTH-1:0];
         flits_d = fsat_w ? CNT_MAX : fsum_w[CNT_WIDTH-1:0];
         ovf_d   = (start_w ? 1'b0 : ovf_q) | bsat_w | fsat_w;
         push_d  = last_q;
      end
   end

   // The record is written one edge after the tlast beat is accumulated.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= ST_OFF;
         bytes_q <= '0;
         flits_q <= '0;
         ovf_q   <= 1'b0;
         push_q  <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         bytes_q <= bytes_d;
         flits_q <= flits_d;
         ovf_q   <= ovf_d;
         push_q  <= push_d;
         busy_q  <= (state_d == ST_BUSY);
         if (push_q && full_w && !pop_w && (drop_q != CNT_MAX)) begin
            drop_q <= drop_q + CNT_WIDTH'(1);
         end
      end
   end

   assign push_rec_w = {bytes_q, flits_q, ovf_q};
   assign pop_w      = rec_valid && rec_ready;

   snoop_rec_fifo #(
      .DEPTH (REC_DEPTH),
      .REC_T (rec_t)
   ) u_rec_fifo (
      .clk         (clk),
      .areset      (areset),
      .push_i      (push_q),
      .push_data_i (push_rec_w),
      .pop_i       (pop_w),
      .head_o      (head_w),
      .empty_o     (empty_w),
      .full_o      (full_w)
   );

   assign rec_valid  = !empty_w;
   assign rec_bytes  = head_w.bytes;
   assign rec_flits  = head_w.flits;
   assign rec_ovf    = head_w.ovf;
   assign drop_count = drop_q;
   assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_snoop_pkt_sequencer.sv
`default_nettype none
// ============================================================================
// tb_snoop_pkt_sequencer : directed plus random stimulus against a packet model
// Rev 1.0
// ============================================================================
module tb_snoop_pkt_sequencer;

   localparam int KW    = 8;
   localparam int DEPTH = 2;

   logic          clk        = 1'b0;
   logic          areset     = 1'b1;
   logic          enable     = 1'b0;
   logic          mon_tvalid = 1'b0;
   logic          mon_tready = 1'b0;
   logic          mon_tlast  = 1'b0;
   logic [KW-1:0] mon_tkeep  = '0;
   logic          rec_ready  = 1'b0;

   logic        rec_valid, rec_ovf, busy;
   logic [15:0] rec_bytes, rec_flits, drop_count;
   logic        s_rec_valid, s_rec_ovf, s_busy;
   logic [3:0]  s_rec_bytes, s_rec_flits, s_drop_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   snoop_pkt_sequencer #(.TDATA_WIDTH(64), .CNT_WIDTH(16), .REC_DEPTH(DEPTH)) u_dut (
      .clk(clk), .areset(areset), .enable(enable),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_bytes(rec_bytes), .rec_flits(rec_flits),
      .rec_ovf(rec_ovf), .drop_count(drop_count), .busy(busy));

   snoop_pkt_sequencer #(.TDATA_WIDTH(64), .CNT_WIDTH(4), .REC_DEPTH(DEPTH)) u_sat (
      .clk(clk), .areset(areset), .enable(enable),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep),
      .rec_valid(s_rec_valid), .rec_ready(rec_ready), .rec_bytes(s_rec_bytes), .rec_flits(s_rec_flits),
      .rec_ovf(s_rec_ovf), .drop_count(s_drop_count), .busy(s_busy));

   // Packet-level reference: raw totals, clamped only when compared.
   typedef enum int {M_OFF, M_SYNC, M_IDLE, M_PKT} mode_t;
   typedef struct {int b; int f;} rec_m_t;

   mode_t  m_mode = M_OFF;
   rec_m_t q[$];
   rec_m_t pend_rec;
   bit     pend = 1'b0;
   int     drops = 0, tot_b = 0, tot_f = 0;
   bit     s1_beat = 1'b0, s1_last = 1'b0;
   int     s1_bytes = 0;

   function automatic int sat(input int v, input int w);
      int m;
      m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   function automatic bit ovf_of(input rec_m_t r, input int w);
      return (r.b > (1 << w) - 1) || (r.f > (1 << w) - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_OFF;
      q.delete();
      pend = 1'b0;
      drops = 0;
      tot_b = 0;
      tot_f = 0;
      s1_beat = 1'b0;
      s1_last = 1'b0;
      s1_bytes = 0;
   endtask

   task automatic model_update();
      bit pop;
      if (areset) begin
         model_reset();
         return;
      end
      pop = (q.size() != 0) && rec_ready;
      if (pop) q.delete(0);
      if (pend) begin
         if (q.size() < DEPTH) q.push_back(pend_rec);
         else drops++;
      end
      pend = 1'b0;
      case (m_mode)
         M_OFF:  if (enable) m_mode = (s1_beat && !s1_last) ? M_SYNC : M_IDLE;
         M_SYNC: if (s1_beat && s1_last) m_mode = enable ? M_IDLE : M_OFF;
         M_IDLE: begin
            if (!enable) m_mode = M_OFF;
            else if (s1_beat) begin
               tot_b = s1_bytes;
               tot_f = 1;
               if (s1_last) begin pend = 1'b1; pend_rec = '{tot_b, tot_f}; end
               else m_mode = M_PKT;
            end
         end
         M_PKT: begin
            if (s1_beat) begin
               tot_b += s1_bytes;
               tot_f += 1;
               if (s1_last) begin pend = 1'b1; pend_rec = '{tot_b, tot_f}; m_mode = M_IDLE; end
            end
         end
         default: m_mode = M_OFF;
      endcase
      s1_beat  = mon_tvalid && mon_tready;
      s1_last  = mon_tlast;
      s1_bytes = $countones(mon_tkeep);
   endtask

   task automatic check_all();
      if (areset) begin
         chk("rst_valid", rec_valid, 0);
         chk("rst_bytes", rec_bytes, 0);
         chk("rst_flits", rec_flits, 0);
         chk("rst_ovf", rec_ovf, 0);
         chk("rst_drop", drop_count, 0);
         chk("rst_busy", busy, 0);
         chk("rst_valid_s", s_rec_valid, 0);
         chk("rst_busy_s", s_busy, 0);
      end else begin
         chk("valid", rec_valid, q.size() != 0);
         chk("valid_s", s_rec_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("bytes", rec_bytes, sat(q[0].b, 16));
            chk("flits", rec_flits, sat(q[0].f, 16));
            chk("ovf", rec_ovf, ovf_of(q[0], 16));
            chk("bytes_s", s_rec_bytes, sat(q[0].b, 4));
            chk("flits_s", s_rec_flits, sat(q[0].f, 4));
            chk("ovf_s", s_rec_ovf, ovf_of(q[0], 4));
         end
         chk("drop", drop_count, sat(drops, 16));
         chk("drop_s", s_drop_count, sat(drops, 4));
         chk("busy", busy, m_mode == M_PKT);
         chk("busy_s", s_busy, m_mode == M_PKT);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic beat(input logic [KW-1:0] keep, input logic last);
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_tkeep  = keep;
      mon_tlast  = last;
      tick();
   endtask

   task automatic idle(input int n);
      mon_tvalid = 1'b0;
      mon_tlast  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic pop_one();
      rec_ready = 1'b1;
      idle(1);
      rec_ready = 1'b0;
   endtask

   initial begin
      model_reset();
      enable = 1'b1;
      idle(2);
      areset = 1'b0;
      idle(1);

      // 3-beat packet 0xFF,0xFF,0x0F
      beat(8'hFF, 1'b0);
      beat(8'hFF, 1'b0);
      beat(8'h0F, 1'b1);
      idle(1);
      chk("t1_not_yet", rec_valid, 0);
      idle(1);
      chk("t1_valid", rec_valid, 1);
      chk("t1_bytes", rec_bytes, 20);
      chk("t1_flits", rec_flits, 3);
      chk("t1_ovf", rec_ovf, 0);
      pop_one();

      // enable rises during beat 2 of 4
      enable = 1'b0;
      idle(2);
      beat(8'hFF, 1'b0);
      enable = 1'b1;
      beat(8'hFF, 1'b0);
      beat(8'hFF, 1'b0);
      beat(8'hFF, 1'b1);
      beat(8'h01, 1'b1);
      idle(2);
      chk("t2_valid", rec_valid, 1);
      chk("t2_bytes", rec_bytes, 1);
      chk("t2_flits", rec_flits, 1);
      pop_one();
      chk("t2_single", rec_valid, 0);

      // enable falls mid-packet
      beat(8'hFF, 1'b0);
      beat(8'hFF, 1'b0);
      enable = 1'b0;
      beat(8'hFF, 1'b1);
      idle(1);
      chk("t3_busy", busy, 0);
      idle(1);
      chk("t3_flits", rec_flits, 3);
      chk("t3_bytes", rec_bytes, 24);
      beat(8'h01, 1'b1);
      idle(3);
      chk("t3_ignored", rec_bytes, 24);
      pop_one();
      chk("t3_empty", rec_valid, 0);

      // overflow of the record buffer
      enable = 1'b1;
      idle(1);
      beat(8'h01, 1'b1);
      beat(8'h03, 1'b1);
      beat(8'h07, 1'b1);
      beat(8'h0F, 1'b1);
      idle(3);
      chk("t4_drop", drop_count, 2);
      chk("t4_head", rec_bytes, 1);
      idle(2);
      chk("t4_stable", rec_bytes, 1);
      pop_one();
      chk("t4_second", rec_bytes, 2);
      pop_one();
      chk("t4_empty", rec_valid, 0);

      // counter saturation on the 4-bit instance
      for (int i = 0; i < 19; i++) beat(8'hFF, 1'b0);
      beat(8'hFF, 1'b1);
      idle(2);
      chk("t5_bytes_s", s_rec_bytes, 15);
      chk("t5_flits_s", s_rec_flits, 15);
      chk("t5_ovf_s", s_rec_ovf, 1);
      chk("t5_bytes", rec_bytes, 160);
      chk("t5_ovf", rec_ovf, 0);
      pop_one();
      beat(8'hFF, 1'b1);
      idle(2);
      chk("t5_next_bytes_s", s_rec_bytes, 8);
      chk("t5_next_ovf_s", s_rec_ovf, 0);
      pop_one();

      // reset while mid-packet
      beat(8'hFF, 1'b0);
      beat(8'hFF, 1'b0);
      chk("t6_busy", busy, 1);
      areset = 1'b1;
      enable = 1'b0;
      model_reset();
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_drop", drop_count, 0);
      idle(1);
      areset = 1'b0;
      enable = 1'b1;
      idle(2);
      beat(8'hFF, 1'b0);
      beat(8'h03, 1'b1);
      idle(2);
      chk("t6_bytes", rec_bytes, 10);
      chk("t6_flits", rec_flits, 2);
      pop_one();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         mon_tvalid = ($urandom_range(0, 3) != 0);
         mon_tready = ($urandom_range(0, 3) != 0);
         mon_tlast  = ($urandom_range(0, 4) == 0);
         mon_tkeep  = KW'($urandom);
         rec_ready  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
